// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with optional even-parity trailer bit.
// Back-to-back frames are accepted while the last bit of a frame is consumed.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             par_q;
    logic             last_data;
    logic             xfer;

    assign last_data = (cnt_q == CW'(WIDTH - 1));
    assign cnt_d     = cnt_q + CW'(1);

    generate
        if (LSB_FIRST) begin : g_lsb
            assign shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin : g_msb
            assign shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_comb begin
        frame_last = 1'b0;
        if (PARITY_EN) begin
            frame_last = (state_q == PARITY);
        end else begin
            frame_last = (state_q == SHIFT) && last_data;
        end
    end

    assign load_ready   = (state_q == IDLE) || (frame_last && shift_en);
    assign xfer         = load_valid && load_ready;
    assign busy         = (state_q != IDLE);
    assign serial_valid = busy;

    always_comb begin
        serial_out = 1'b0;
        unique case (state_q)
            SHIFT:   serial_out = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
            PARITY:  serial_out = par_q;
            default: serial_out = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_q <= SHIFT;
                        shreg_q <= load_data;
                        cnt_q   <= '0;
                        par_q   <= ^load_data;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_d;
                        if (last_data) begin
                            if (PARITY_EN) begin
                                state_q <= PARITY;
                            end else if (xfer) begin
                                shreg_q <= load_data;
                                cnt_q   <= '0;
                                par_q   <= ^load_data;
                            end else begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (shift_en) begin
                        if (xfer) begin
                            state_q <= SHIFT;
                            shreg_q <= load_data;
                            cnt_q   <= '0;
                            par_q   <= ^load_data;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 0; 0 = MSB shifted first, 1 = LSB shifted first.
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 = append one even-parity bit after the data bits.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: load_valid  input  1  parallel word offered.
REQ-008 SHALL have port: load_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port: load_data  input  WIDTH  parallel word.
REQ-010 SHALL have port: shift_en  input  1  consume the presented serial bit at this edge.
REQ-011 SHALL have port: serial_out  output  1  currently presented bit.
REQ-012 SHALL have port: serial_valid  output  1  serial_out holds a frame bit.
REQ-013 SHALL have port: frame_last  output  1  presented bit is the final bit of the frame.
REQ-014 SHALL have port: busy  output  1  a frame is in progress.

Function
REQ-015 SHALL implement states IDLE, SHIFT and PARITY; PARITY is reachable only when PARITY_EN=1.
REQ-016 SHALL accept a word on a rising edge with load_valid=1 and load_ready=1 (a transfer): capture load_data, compute even parity (XOR of all bits), clear the bit counter and enter SHIFT.
REQ-017 SHALL drive load_ready=1 in IDLE, and also in the cycle where the final frame bit is presented with shift_en=1 (back-to-back); otherwise 0.
REQ-018 SHALL present the first bit in the cycle after the transfer edge (latency 1), with no idle gap between frames on back-to-back transfers.
REQ-019 SHALL, in SHIFT, drive serial_out to the MSB (LSB_FIRST=0) or the LSB (LSB_FIRST=1) of the remaining word, and advance one bit and the counter only on edges where shift_en=1.
REQ-020 SHALL hold serial_out, the counter and the state unchanged while shift_en=0 (stall, unbounded).
REQ-021 SHALL, after data bit WIDTH-1 is consumed, go to PARITY if PARITY_EN=1, else to SHIFT on a simultaneous transfer, else to IDLE.
REQ-022 SHALL, in PARITY, drive the stored parity bit on serial_out; after it is consumed, go to SHIFT on a simultaneous transfer, else to IDLE.
REQ-023 SHALL drive serial_valid=1 and busy=1 in SHIFT and PARITY; both SHALL be 0 in IDLE.
REQ-024 SHALL assert frame_last only while presenting data bit WIDTH-1 (PARITY_EN=0) or the parity bit (PARITY_EN=1).
REQ-025 SHALL drive serial_out=0 in IDLE.
REQ-026 SHALL size the bit counter at clog2(WIDTH+1) bits; it SHALL never exceed WIDTH.
REQ-027 SHALL ignore load_valid while load_ready=0; load_data is not sampled except at a transfer.

Reset
REQ-028 SHALL, on reset=1 at any time including mid-frame, immediately enter IDLE and clear the shift register, counter and parity bit; the partial frame is discarded.
REQ-029 SHALL, during and after reset, present load_ready=1, serial_out=0, serial_valid=0, frame_last=0 and busy=0.
REQ-030 SHALL start the first frame after reset release only on a subsequent transfer.

Verification
REQ-031 SHALL verify this case: WIDTH=8, LSB_FIRST=0, load 0xC1, shift_en=1 continuously -> serial_out 1,1,0,0,0,0,0,1 on the 8 cycles after the load, frame_last on the 8th, then IDLE.
REQ-032 SHALL verify this case: LSB_FIRST=1, load 0xC1 -> serial_out 1,0,0,0,0,0,1,1.
REQ-033 SHALL verify this case: PARITY_EN=1, load 0xC1 -> 8 data bits then a parity bit of 1, with frame_last on that 9th bit only.
REQ-034 SHALL verify this case: stall with shift_en=0 for 5 cycles after bit 3 -> serial_out and frame_last hold; the sequence resumes unchanged with no bit lost or duplicated.
REQ-035 SHALL verify this case: 0xC1 then 0x3C offered back-to-back -> 16 consecutive valid bits with no gap, and load_ready high in the frame_last cycle.
REQ-036 SHALL verify this case: reset asserted after bit 4 of 0xFF -> outputs take reset values in the same cycle; a new load of 0x01 then serializes correctly.
